// File: rtl/multdiv_controller_if.sv
// Request, response and unit-side signals of the multiply/divide controller.
// master = requester plus arithmetic units, slave = the controller itself.
interface multdiv_controller_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and the sender holds its payload
  // stable while valid is high and ready is low.
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] mult_result;
  logic             mult_exception;
  logic             mult_resultRDY;
  logic [WIDTH-1:0] div_result;
  logic             div_exception;
  logic             div_resultRDY;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_exception;
  logic             resp_timeout;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
           mult_result, mult_exception, mult_resultRDY,
           div_result, div_exception, div_resultRDY,
    input  req_ready, op_a, op_b, ctrl_MULT, ctrl_DIV,
           resp_valid, resp_result, resp_exception, resp_timeout, resp_tag, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
           mult_result, mult_exception, mult_resultRDY,
           div_result, div_exception, div_resultRDY,
    output req_ready, op_a, op_b, ctrl_MULT, ctrl_DIV,
           resp_valid, resp_result, resp_exception, resp_timeout, resp_tag, busy
  );
endinterface

// File: rtl/multdiv_controller.sv
// Sequences one multiply or divide at a time through an external unit, with a watchdog.
// Optional MULTDIV_ZERO_BYPASS_EN: multiplies with a zero operand complete without the unit.
module multdiv_controller #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 5,
  parameter int MAX_CYCLES = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_controller_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [7:0] LP_LAST_CNT = 8'(MAX_CYCLES - 1);

  state_t           r_state, w_next_state;
  logic             r_op, w_op;
  logic [WIDTH-1:0] r_op_a, w_op_a, r_op_b, w_op_b;
  logic             r_ctrl_mult, w_ctrl_mult, r_ctrl_div, w_ctrl_div;
  logic [7:0]       r_cnt, w_cnt;
  logic             r_req_ready, w_req_ready, r_busy;
  logic             r_resp_valid, w_resp_valid;
  logic [WIDTH-1:0] r_resp_result, w_resp_result;
  logic             r_resp_exception, w_resp_exception;
  logic             r_resp_timeout, w_resp_timeout;
  logic [TAG_W-1:0] r_resp_tag, w_resp_tag;

  // Only the unit that was launched may complete the operation.
  logic             w_sel_rdy, w_sel_exc;
  logic [WIDTH-1:0] w_sel_result;
  assign w_sel_rdy    = r_op ? bus.div_resultRDY  : bus.mult_resultRDY;
  assign w_sel_exc    = r_op ? bus.div_exception  : bus.mult_exception;
  assign w_sel_result = r_op ? bus.div_result     : bus.mult_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_op             <= 1'b0;
      r_op_a           <= '0;
      r_op_b           <= '0;
      r_ctrl_mult      <= 1'b0;
      r_ctrl_div       <= 1'b0;
      r_cnt            <= '0;
      r_req_ready      <= 1'b1;
      r_busy           <= 1'b0;
      r_resp_valid     <= 1'b0;
      r_resp_result    <= '0;
      r_resp_exception <= 1'b0;
      r_resp_timeout   <= 1'b0;
      r_resp_tag       <= '0;
    end else begin
      r_state          <= w_next_state;
      r_op             <= w_op;
      r_op_a           <= w_op_a;
      r_op_b           <= w_op_b;
      r_ctrl_mult      <= w_ctrl_mult;
      r_ctrl_div       <= w_ctrl_div;
      r_cnt            <= w_cnt;
      r_req_ready      <= w_req_ready;
      r_busy           <= ~w_req_ready;
      r_resp_valid     <= w_resp_valid;
      r_resp_result    <= w_resp_result;
      r_resp_exception <= w_resp_exception;
      r_resp_timeout   <= w_resp_timeout;
      r_resp_tag       <= w_resp_tag;
    end
  end

  // Next values for every register; the control pulse is set on the edge that
  // enters LAUNCH so that it is high for exactly the LAUNCH cycle.
  always_comb begin
    w_next_state     = r_state;
    w_op             = r_op;
    w_op_a           = r_op_a;
    w_op_b           = r_op_b;
    w_ctrl_mult      = 1'b0;
    w_ctrl_div       = 1'b0;
    w_cnt            = r_cnt;
    w_resp_valid     = r_resp_valid;
    w_resp_result    = r_resp_result;
    w_resp_exception = r_resp_exception;
    w_resp_timeout   = r_resp_timeout;
    w_resp_tag       = r_resp_tag;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_op         = bus.req_op;
          w_op_a       = bus.req_a;
          w_op_b       = bus.req_b;
          w_resp_tag   = bus.req_tag;
          w_ctrl_mult  = ~bus.req_op;
          w_ctrl_div   = bus.req_op;
          w_next_state = LAUNCH;
`ifdef MULTDIV_ZERO_BYPASS_EN
          if (!bus.req_op && ((bus.req_a == '0) || (bus.req_b == '0))) begin
            w_ctrl_mult      = 1'b0;
            w_resp_valid     = 1'b1;
            w_resp_result    = '0;
            w_resp_exception = 1'b0;
            w_resp_timeout   = 1'b0;
            w_next_state     = DONE;
          end
`endif
        end
      end
      LAUNCH: begin
        w_cnt        = '0;
        w_next_state = WAIT;
      end
      WAIT: begin
        w_cnt = r_cnt + 8'd1;
        if (w_sel_rdy) begin
          w_resp_valid     = 1'b1;
          w_resp_result    = w_sel_result;
          w_resp_exception = w_sel_exc;
          w_resp_timeout   = 1'b0;
          w_next_state     = DONE;
        end else if (r_cnt == LP_LAST_CNT) begin
          w_resp_valid     = 1'b1;
          w_resp_result    = '0;
          w_resp_exception = 1'b1;
          w_resp_timeout   = 1'b1;
          w_next_state     = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          w_resp_valid = 1'b0;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    w_req_ready = (w_next_state == IDLE);
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.busy           = r_busy;
  assign bus.op_a           = r_op_a;
  assign bus.op_b           = r_op_b;
  assign bus.ctrl_MULT      = r_ctrl_mult;
  assign bus.ctrl_DIV       = r_ctrl_div;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_result    = r_resp_result;
  assign bus.resp_exception = r_resp_exception;
  assign bus.resp_timeout   = r_resp_timeout;
  assign bus.resp_tag       = r_resp_tag;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller; expected values are hand-computed per vector.
module tb_multdiv_controller;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;
  int         n_mult_pulse;
  int         n_div_pulse;
  int         p_mult;
  int         p_div;
  int         n_wait;

  multdiv_controller_if #(.WIDTH(32), .TAG_W(5)) bus ();

  multdiv_controller #(.WIDTH(32), .TAG_W(5), .MAX_CYCLES(40)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ctrl_MULT) n_mult_pulse++;
    if (bus.ctrl_DIV)  n_div_pulse++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic release_resp(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_idle_valid"}, bus.resp_valid, 0);
    check({tag, "_idle_ready"}, bus.req_ready, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_mult_pulse = 0; n_div_pulse = 0;
    rst = 1'b1;
    bus.req_valid = 0; bus.req_op = 0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.resp_ready = 0;
    bus.mult_result = '0; bus.mult_exception = 0; bus.mult_resultRDY = 0;
    bus.div_result = '0;  bus.div_exception = 0;  bus.div_resultRDY = 0;
    tick(); tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ctrl", {bus.ctrl_MULT, bus.ctrl_DIV}, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_flags", {bus.resp_exception, bus.resp_timeout}, 0);
    check("rst_op_a", bus.op_a, 0);
    check("rst_result", bus.resp_result, 0);
    check("rst_tag", bus.resp_tag, 0);
    rst = 1'b0;
    tick();

    // mul 7 x 6, stale ready held through LAUNCH, foreign div ready during WAIT
    p_mult = n_mult_pulse; p_div = n_div_pulse;
    bus.mult_resultRDY = 1; bus.mult_result = 32'd99;
    accept(0, 32'd7, 32'd6, 5'd3);
    check("mul_launch_ctrl", {bus.ctrl_MULT, bus.ctrl_DIV}, 2'b10);
    check("mul_launch_ready", bus.req_ready, 0);
    check("mul_launch_busy", bus.busy, 1);
    check("mul_op_a", bus.op_a, 7);
    check("mul_op_b", bus.op_b, 6);
    tick();
    bus.mult_resultRDY = 0;
    bus.div_resultRDY = 1; bus.div_result = 32'hDEAD;
    check("mul_wait_ctrl", bus.ctrl_MULT, 0);
    check("mul_stale_ignored", bus.resp_valid, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("mul_wait_ready", bus.req_ready, 0);
      check("mul_wait_valid", bus.resp_valid, 0);
    end
    bus.div_resultRDY = 0;
    bus.mult_resultRDY = 1; bus.mult_result = 32'd42;
    tick();
    bus.mult_resultRDY = 0;
    check("mul_valid", bus.resp_valid, 1);
    check("mul_result", bus.resp_result, 42);
    check("mul_tag", bus.resp_tag, 3);
    check("mul_flags", {bus.resp_exception, bus.resp_timeout}, 0);
    check("mul_pulses", n_mult_pulse - p_mult, 1);
    check("mul_no_div", n_div_pulse - p_div, 0);
    release_resp("mul");

    // div 100 / 0 with unit exception
    p_mult = n_mult_pulse; p_div = n_div_pulse;
    accept(1, 32'd100, 32'd0, 5'd5);
    check("div_launch_ctrl", {bus.ctrl_MULT, bus.ctrl_DIV}, 2'b01);
    tick(); tick(); tick();
    bus.div_resultRDY = 1; bus.div_exception = 1; bus.div_result = 32'hFFFF_FFFF;
    tick();
    bus.div_resultRDY = 0; bus.div_exception = 0;
    check("div_valid", bus.resp_valid, 1);
    check("div_exc", bus.resp_exception, 1);
    check("div_timeout", bus.resp_timeout, 0);
    check("div_result", bus.resp_result, 32'hFFFF_FFFF);
    check("div_tag", bus.resp_tag, 5);
    check("div_pulses", n_div_pulse - p_div, 1);
    check("div_no_mult", n_mult_pulse - p_mult, 0);
    release_resp("div");

    // watchdog: unit never ready
    accept(0, 32'd9, 32'd9, 5'd7);
    tick();
    n_wait = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_wait++;
      if (bus.resp_valid) break;
    end
    check("to_wait_cycles", n_wait, 40);
    check("to_valid", bus.resp_valid, 1);
    check("to_result", bus.resp_result, 0);
    check("to_flags", {bus.resp_exception, bus.resp_timeout}, 2'b11);
    check("to_tag", bus.resp_tag, 7);

    // back-pressure: response held while a new request waits
    p_mult = n_mult_pulse;
    bus.req_valid = 1; bus.req_op = 0; bus.req_a = 32'd2; bus.req_b = 32'd3; bus.req_tag = 5'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.resp_valid, 1);
      check("bp_fields", {bus.resp_result, bus.resp_exception, bus.resp_timeout, bus.resp_tag},
            {32'd0, 1'b1, 1'b1, 5'd7});
      check("bp_no_accept", bus.req_ready, 0);
    end
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    check("bp_idle_ready", bus.req_ready, 1);
    check("bp_idle_valid", bus.resp_valid, 0);
    check("bp_no_launch", n_mult_pulse - p_mult, 0);
    tick();
    bus.req_valid = 0;
    check("bp_accept_ctrl", bus.ctrl_MULT, 1);
    check("bp_accept_op_a", bus.op_a, 2);
    tick();
    bus.mult_resultRDY = 1; bus.mult_result = 32'd6;
    tick();
    bus.mult_resultRDY = 0;
    check("bp_result", bus.resp_result, 6);
    check("bp_tag", bus.resp_tag, 1);
    release_resp("bp");

    // reset pulsed during WAIT, late ready afterwards
    accept(0, 32'd4, 32'd4, 5'd2);
    tick(); tick(); tick();
    rst = 1;
    #1;
    check("ar_req_ready", bus.req_ready, 1);
    check("ar_busy", bus.busy, 0);
    check("ar_valid", bus.resp_valid, 0);
    check("ar_op_a", bus.op_a, 0);
    check("ar_tag", bus.resp_tag, 0);
    check("ar_state", dbg_state, 0);
    tick();
    rst = 0;
    bus.mult_resultRDY = 1; bus.mult_result = 32'd16;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_late_ignored", bus.resp_valid, 0);
    end
    bus.mult_resultRDY = 0;
    accept(0, 32'd3, 32'd5, 5'd4);
    tick(); tick();
    bus.mult_resultRDY = 1; bus.mult_result = 32'd15;
    tick();
    bus.mult_resultRDY = 0;
    check("ar_mul_valid", bus.resp_valid, 1);
    check("ar_mul_result", bus.resp_result, 15);
    check("ar_mul_tag", bus.resp_tag, 4);
    release_resp("ar");

    // mul 0 x 12345
    p_mult = n_mult_pulse;
    accept(0, 32'd0, 32'd12345, 5'd6);
`ifdef MULTDIV_ZERO_BYPASS_EN
    check("zb_valid", bus.resp_valid, 1);
    check("zb_no_ctrl", bus.ctrl_MULT, 0);
`else
    check("zb_ctrl", bus.ctrl_MULT, 1);
    check("zb_not_valid", bus.resp_valid, 0);
    tick();
    bus.mult_resultRDY = 1; bus.mult_result = 32'd0;
    tick();
    bus.mult_resultRDY = 0;
    check("zb_valid", bus.resp_valid, 1);
`endif
    check("zb_result", bus.resp_result, 0);
    check("zb_flags", {bus.resp_exception, bus.resp_timeout}, 0);
    check("zb_tag", bus.resp_tag, 6);
`ifdef MULTDIV_ZERO_BYPASS_EN
    check("zb_pulses", n_mult_pulse - p_mult, 0);
`else
    check("zb_pulses", n_mult_pulse - p_mult, 1);
`endif
    release_resp("zb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_controller.md
MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have parameter MAX_CYCLES, default 40, legal 1..255: watchdog limit in WAIT cycles.
REQ-004 SHALL have: clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have: reset  in  1  asynchronous, active-high.
REQ-006 SHALL have request ports: req_valid in 1; req_ready out 1; req_op in 1 (0 = multiply, 1 = divide); req_a in WIDTH; req_b in WIDTH; req_tag in TAG_W.
REQ-007 SHALL have unit-side outputs: op_a out WIDTH; op_b out WIDTH; ctrl_MULT out 1; ctrl_DIV out 1.
REQ-008 SHALL have unit-side inputs: mult_result in WIDTH; mult_exception in 1; mult_resultRDY in 1; div_result in WIDTH; div_exception in 1; div_resultRDY in 1.
REQ-009 SHALL have response ports: resp_valid out 1; resp_ready in 1; resp_result out WIDTH; resp_exception out 1; resp_timeout out 1; resp_tag out TAG_W; busy out 1.

Function
REQ-010 SHALL implement states IDLE, LAUNCH, WAIT, DONE; all outputs registered.
REQ-011 SHALL drive req_ready = 1 only in IDLE; busy = NOT req_ready.
REQ-012 SHALL accept a request on an edge with req_valid AND req_ready: latch op, a, b and tag; go to LAUNCH.
REQ-013 SHALL hold op_a and op_b at the latched values from the cycle after acceptance until return to IDLE.
REQ-014 SHALL, in LAUNCH, assert exactly one of ctrl_MULT or ctrl_DIV (selected by latched op) for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-015 SHALL ignore both resultRDY inputs in IDLE, LAUNCH and DONE, so a stale ready from a previous operation is never taken.
REQ-016 SHALL, in WAIT, use only the selected unit's resultRDY; a ready from the non-selected unit is ignored.
REQ-017 SHALL, in WAIT, increment the watchdog counter each cycle.
REQ-018 SHALL, on the first WAIT cycle with the selected resultRDY = 1, capture the unit's result into resp_result and its exception into resp_exception, set resp_timeout = 0, and go to DONE.
REQ-019 SHALL, if the counter reaches MAX_CYCLES without a ready, go to DONE with resp_result = 0, resp_exception = 1 and resp_timeout = 1.
REQ-020 SHALL give ready precedence over timeout when both occur on the same cycle.
REQ-021 SHALL assert resp_valid throughout DONE, holding resp_result, resp_exception, resp_timeout and resp_tag stable until resp_ready = 1.
REQ-022 SHALL go from DONE to IDLE on the edge with resp_ready = 1; a new request is accepted no earlier than the following edge (one-cycle bubble).
REQ-023 SHALL pass divide-by-zero and overflow through unchanged from the unit's exception input; it performs no arithmetic checking of its own.

Reset
REQ-024 SHALL, on reset assertion (immediately, including mid-operation), enter IDLE.
REQ-025 SHALL, on reset, drive ctrl_MULT, ctrl_DIV, resp_valid, resp_exception, resp_timeout and busy to 0, drive req_ready to 1, and clear op_a, op_b, resp_result, resp_tag and the watchdog counter to 0.
REQ-026 SHALL ignore unit results that arrive after a reset aborted their operation.

Configuration
REQ-027 SHALL support macro MULTDIV_ZERO_BYPASS_EN.
REQ-028 SHALL, with MULTDIV_ZERO_BYPASS_EN defined, route an accepted multiply with req_a == 0 or req_b == 0 straight to DONE on the acceptance edge: resp_result = 0, resp_exception = 0, resp_timeout = 0, no ctrl_MULT pulse; divides are never bypassed.
REQ-029 SHALL, without MULTDIV_ZERO_BYPASS_EN, send every operation through LAUNCH and WAIT.

Verification
REQ-030 SHALL test: mul 7 x 6, tag 3; unit model holds mult_resultRDY high during LAUNCH, then raises a genuine ready 16 cycles later -> one-cycle ctrl_MULT the cycle after acceptance, stale ready ignored, resp 42/tag 3/exception 0, req_ready 0 throughout.
REQ-031 SHALL test: div 100 / 0; model returns div_exception = 1 -> one ctrl_DIV pulse, no ctrl_MULT, resp_exception 1, resp_timeout 0.
REQ-032 SHALL test: mul with unit never ready, MAX_CYCLES = 40 -> resp_valid after exactly 40 WAIT cycles with result 0, exception 1, timeout 1.
REQ-033 SHALL test: resp_ready held low 5 cycles while req_valid = 1 -> response fields stable, no new acceptance, acceptance only on the edge after resp_ready.
REQ-034 SHALL test: reset pulsed in WAIT, model ready arrives later -> outputs at reset values immediately, late ready ignored, next mul 3 x 5 returns 15.
REQ-035 SHALL test: mul 0 x 12345 -> with macro, resp_valid the cycle after acceptance with no ctrl_MULT; without macro, normal ctrl_MULT path, result 0.
